cv32e40p_breakage_monitor_array: RTL
====================================

Name: cv32e40p_breakage_monitor_array

Overview:
Parametrised multi-channel breakage monitor for the fault-tolerant pipeline blocks (prefetch buffer, aligner, compressed decoder, IF pipeline, ...). Each channel takes the per-cycle mismatch flag from one voter or checker. It keeps a leaky-bucket error counter with configurable increment, decrement, threshold, saturation and decay period. It declares the channel broken when the count reaches the threshold, and reports the lowest-index broken channel plus a one-cycle new-breakage pulse. It replaces the fixed single-counter monitors with one N-channel instance, and adds decay pacing, sticky/non-sticky breakage and per-channel clear.

Parameters:
N_CH, 5, number of monitored channels (>=1)
COUNT_BIT, 8, width of each error counter
INC_DEC_BIT, 2, width of the INCREMENT/DECREMENT constants
INCREMENT, 1, added to the count on an error cycle; must be < 2**INC_DEC_BIT
DECREMENT, 1, subtracted from the count on each decay event; must be < 2**INC_DEC_BIT
BREAKING_THRESHOLD, 3, count at or above which a channel is broken; 1..2**COUNT_BIT-1
DECAY_PERIOD, 1, number of consecutive clean valid cycles per decay event (>=1)
STICKY, 1, 1: broken latches until clear_i; 0: broken follows the count

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
valid_i  in  N_CH  channel sample valid; when low the channel holds all its state
err_i  in  N_CH  mismatch flag, sampled only when valid_i is set
clear_i  in  N_CH  synchronous per-channel clear (after repair or reconfiguration)
count_o  out  N_CH*COUNT_BIT  packed counters; channel k occupies [k*COUNT_BIT +: COUNT_BIT]
broken_o  out  N_CH  channel is in BROKEN
degraded_o  out  N_CH  channel is in DEGRADED (count > 0, not broken)
any_broken_o  out  1  OR of broken_o
first_broken_o  out  max(1,$clog2(N_CH))  lowest broken index; 0 when none is broken
new_break_o  out  1  one-cycle pulse when any channel enters BROKEN

Behaviour:
- Reset: all counters, decay counters and outputs are 0; every channel is in OK. Reset is asynchronous; it aborts any operation in flight mid-cycle.
- All outputs are registered. An event sampled at edge t is visible after edge t.
- Per-channel priority:
  - clear_i: count=0, decay=0, state=OK, whatever valid_i/err_i are.
  - else valid_i&&err_i: count=min(count+INCREMENT, 2**COUNT_BIT-1), decay=0.
  - else valid_i&&!err_i:
    - if decay==DECAY_PERIOD-1: decay=0 and count=max(count-DECREMENT, 0).
    - else: decay=decay+1.
  - else (valid_i low): hold.
- Arithmetic: compute in COUNT_BIT+1 bits, then saturate at both ends. The count never wraps.
- Decay counter width is $clog2(DECAY_PERIOD)+1. DECAY_PERIOD=1 decrements on every clean cycle.
- States are computed from the next count and registered together with it:
  - OK -> DEGRADED when next count > 0 and < threshold.
  - OK/DEGRADED -> BROKEN when next count >= threshold.
  - DEGRADED -> OK when next count == 0.
  - BROKEN with STICKY=1: stays BROKEN until clear_i; the count keeps updating.
  - BROKEN with STICKY=0: leaves to DEGRADED or OK as soon as next count < threshold.
- new_break_o: registered OR over channels entering BROKEN this edge.
  - A channel that re-enters BROKEN (STICKY=0) pulses again.
  - Several channels breaking on the same edge give one pulse.
- first_broken_o is a priority encode of the registered broken_o; index 0 wins.
- The module rejects illegal parameters at elaboration with $error: INCREMENT or DECREMENT >= 2**INC_DEC_BIT, threshold 0 or > 2**COUNT_BIT-1, DECAY_PERIOD 0.

Decomposition:
- cv32e40p_pkg2 gains:
  - typedef enum logic [1:0] {BM_OK, BM_DEGRADED, BM_BROKEN} bm_state_e
  - BM_* default constants mirroring the per-block DECREMENT, INCREMENT, BREAKING_THRESHOLD, COUNT_BIT and INC_DEC_BIT values.
- One sub-module, cv32e40p_breakage_counter: the single-channel counter, decay logic and FSM. It is instantiated N_CH times in a generate loop.
- The top level holds the OR, priority encoder and pulse register.

Test Plan:
- Defaults; ch0 valid+err for 3 cycles -> count_o[0] 1,2,3; broken_o[0]=1 and new_break_o=1 for exactly one cycle after the 3rd edge; first_broken_o=0; any_broken_o=1.
- DECAY_PERIOD=4, ch2 count=2, then 8 clean valid cycles -> count 1 after the 4th clean edge, 0 after the 8th; degraded_o[2] falls with count 0; an err on the 6th cycle restarts decay and gives count 2.
- COUNT_BIT=3, INCREMENT=2, BREAKING_THRESHOLD=7, ch1 erroring continuously -> count 2,4,6,7,7; broken at the 4th edge; no wrap.
- ch3 clear_i and err_i high on the same edge while broken -> count 0, state OK, no new_break_o; with valid_i low and err_i high the channel holds all state.
- STICKY=0 vs STICKY=1, ch4 at count 3 then 1 clean cycle -> STICKY=0: count 2, broken_o[4] falls, degraded_o[4] rises; STICKY=1: broken_o[4] stays 1 until clear_i.
- ch1 and ch3 break on the same edge -> first_broken_o=1, single new_break_o pulse; assert rst_n low mid-cycle -> all outputs 0 immediately, counters 0 after release.

Source files
------------

// File: rtl/cv32e40p_pkg2.sv
// Shared types and default constants for the breakage monitors of the
// fault-tolerant pipeline blocks.
package cv32e40p_pkg2;

  typedef enum logic [1:0] {
    BM_OK       = 2'd0,
    BM_DEGRADED = 2'd1,
    BM_BROKEN   = 2'd2
  } bm_state_e;

  // Defaults matching the fixed single-counter monitors this array replaces.
  localparam int BM_COUNT_BIT          = 8;
  localparam int BM_INC_DEC_BIT        = 2;
  localparam int BM_INCREMENT          = 1;
  localparam int BM_DECREMENT          = 1;
  localparam int BM_BREAKING_THRESHOLD = 3;
  localparam int BM_DECAY_PERIOD       = 1;
  localparam int BM_STICKY             = 1;

endpackage

// File: rtl/cv32e40p_breakage_counter.sv
// Single-channel leaky-bucket error counter with decay pacing and
// OK / DEGRADED / BROKEN state tracking.
module cv32e40p_breakage_counter
  import cv32e40p_pkg2::*;
#(
  parameter int COUNT_BIT          = BM_COUNT_BIT,
  parameter int INCREMENT          = BM_INCREMENT,
  parameter int DECREMENT          = BM_DECREMENT,
  parameter int BREAKING_THRESHOLD = BM_BREAKING_THRESHOLD,
  parameter int DECAY_PERIOD       = BM_DECAY_PERIOD,
  parameter int STICKY             = BM_STICKY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic                 err,
  input  logic                 clear,
  output logic [COUNT_BIT-1:0] count,
  output bm_state_e            state,
  output logic                 enter_break
);

  localparam int                  DECAY_W    = $clog2(DECAY_PERIOD) + 1;
  localparam logic [COUNT_BIT:0]  CNT_MAX    = {1'b0, {COUNT_BIT{1'b1}}};
  localparam logic [COUNT_BIT:0]  INC_EXT    = (COUNT_BIT + 1)'(INCREMENT);
  localparam logic [COUNT_BIT:0]  DEC_EXT    = (COUNT_BIT + 1)'(DECREMENT);
  localparam logic [COUNT_BIT-1:0] THRESH    = COUNT_BIT'(BREAKING_THRESHOLD);
  localparam logic [DECAY_W-1:0]  DECAY_LAST = DECAY_W'(DECAY_PERIOD - 1);

  logic [DECAY_W-1:0]   decay, decay_next;
  logic [COUNT_BIT-1:0] count_next;
  logic [COUNT_BIT:0]   sum, diff;
  bm_state_e            state_next;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    sum        = {1'b0, count} + INC_EXT;
    diff       = {1'b0, count} - DEC_EXT;
    count_next = count;
    decay_next = decay;
    if (clear) begin
      count_next = '0;
      decay_next = '0;
    end else if (valid && err) begin
      count_next = (sum > CNT_MAX) ? '1 : sum[COUNT_BIT-1:0];
      decay_next = '0;
    end else if (valid) begin
      if (decay == DECAY_LAST) begin
        decay_next = '0;
        // The extra MSB flags an underflow, which clamps to zero.
        count_next = diff[COUNT_BIT] ? '0 : diff[COUNT_BIT-1:0];
      end else begin
        decay_next = decay + DECAY_W'(1);
      end
    end
  end

  always_comb begin
    state_next = BM_DEGRADED;
    if (clear)                                   state_next = BM_OK;
    else if (count_next >= THRESH)               state_next = BM_BROKEN;
    else if (STICKY != 0 && state == BM_BROKEN)  state_next = BM_BROKEN;
    else if (count_next == '0)                   state_next = BM_OK;
  end

  assign enter_break = (state_next == BM_BROKEN) && (state != BM_BROKEN);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      decay <= '0;
      state <= BM_OK;
    end else begin
      count <= count_next;
      decay <= decay_next;
      state <= state_next;
    end
  end

endmodule

// File: rtl/cv32e40p_breakage_monitor_array.sv
// N-channel breakage monitor: one counter per channel plus the shared
// broken summary, lowest-index encoder and new-breakage pulse.
module cv32e40p_breakage_monitor_array
  import cv32e40p_pkg2::*;
#(
  parameter int N_CH               = 5,
  parameter int COUNT_BIT          = BM_COUNT_BIT,
  parameter int INC_DEC_BIT        = BM_INC_DEC_BIT,
  parameter int INCREMENT          = BM_INCREMENT,
  parameter int DECREMENT          = BM_DECREMENT,
  parameter int BREAKING_THRESHOLD = BM_BREAKING_THRESHOLD,
  parameter int DECAY_PERIOD       = BM_DECAY_PERIOD,
  parameter int STICKY             = BM_STICKY
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_CH-1:0]                       valid_i,
  input  logic [N_CH-1:0]                       err_i,
  input  logic [N_CH-1:0]                       clear_i,
  output logic [N_CH*COUNT_BIT-1:0]             count_o,
  output logic [N_CH-1:0]                       broken_o,
  output logic [N_CH-1:0]                       degraded_o,
  output logic                                  any_broken_o,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] first_broken_o,
  output logic                                  new_break_o
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  if (INCREMENT >= (1 << INC_DEC_BIT)) begin : g_bad_increment
    $error("INCREMENT must be below 2**INC_DEC_BIT");
  end
  if (DECREMENT >= (1 << INC_DEC_BIT)) begin : g_bad_decrement
    $error("DECREMENT must be below 2**INC_DEC_BIT");
  end
  if (BREAKING_THRESHOLD < 1 || BREAKING_THRESHOLD > (1 << COUNT_BIT) - 1) begin : g_bad_threshold
    $error("BREAKING_THRESHOLD must lie in 1..2**COUNT_BIT-1");
  end
  if (DECAY_PERIOD < 1) begin : g_bad_decay
    $error("DECAY_PERIOD must be at least 1");
  end

  bm_state_e       state [N_CH];
  logic [N_CH-1:0] enter_break;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    cv32e40p_breakage_counter #(
      .COUNT_BIT         (COUNT_BIT),
      .INCREMENT         (INCREMENT),
      .DECREMENT         (DECREMENT),
      .BREAKING_THRESHOLD(BREAKING_THRESHOLD),
      .DECAY_PERIOD      (DECAY_PERIOD),
      .STICKY            (STICKY)
    ) u_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid      (valid_i[g]),
      .err        (err_i[g]),
      .clear      (clear_i[g]),
      .count      (count_o[g*COUNT_BIT +: COUNT_BIT]),
      .state      (state[g]),
      .enter_break(enter_break[g])
    );
    assign broken_o[g]   = (state[g] == BM_BROKEN);
    assign degraded_o[g] = (state[g] == BM_DEGRADED);
  end

  assign any_broken_o = |broken_o;

  // Scanning downwards lets the lowest broken index overwrite higher ones.
  always_comb begin
    first_broken_o = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (broken_o[i]) first_broken_o = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) new_break_o <= 1'b0;
    else        new_break_o <= |enter_break;
  end

endmodule
